// File: rtl/mux_rr_arbiter.sv
// ============================================================================
//  Module      : mux_rr_arbiter
//  Description : Two-requester round-robin arbiter driving a shared 2:1 data
//                mux and a single registered output stage. A grant is held
//                for up to BURST accepted beats while the other side waits,
//                then hands over with no idle cycle in between.
//  Ports       : clk, rst_n            - clock, async active-low reset
//                I0_valid/data/ready   - requester 0 valid/ready stream
//                I1_valid/data/ready   - requester 1 valid/ready stream
//                out_valid/data/ready  - registered output stream
//                S                     - mux select / current grant
//                busy                  - arbiter is holding a grant
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_rr_arbiter #(
    parameter int WIDTH = 8,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             I0_valid,
    input  logic [WIDTH-1:0] I0_data,
    output logic             I0_ready,
    input  logic             I1_valid,
    input  logic [WIDTH-1:0] I1_data,
    output logic             I1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             S,
    output logic             busy
);

    // Counter must be able to hold the saturated value BURST itself.
    localparam int                 CNT_W   = $clog2(BURST + 1);
    localparam logic [CNT_W-1:0]   C_BURST = CNT_W'(BURST);
    localparam logic [CNT_W-1:0]   C_LAST  = CNT_W'(BURST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               r_last;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_s;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out_data;

    logic               w_space;
    logic               w_acc0;
    logic               w_acc1;
    logic               w_acc;
    logic               w_cur_valid;
    logic               w_oth_valid;
    logic               w_burst_hit;

    // The output register can take a beat when empty or when it drains now.
    assign w_space  = !r_out_valid | out_ready;
    assign I0_ready = (r_state == GNT0) & w_space;
    assign I1_ready = (r_state == GNT1) & w_space;
    assign w_acc0   = I0_valid & I0_ready;
    assign w_acc1   = I1_valid & I1_ready;
    assign w_acc    = w_acc0 | w_acc1;

    // Valid of the granted side and of the waiting side (don't-care in IDLE).
    assign w_cur_valid = (r_state == GNT1) ? I1_valid : I0_valid;
    assign w_oth_valid = (r_state == GNT1) ? I0_valid : I1_valid;

    // This accept is the BURST-th beat of the grant (or beyond, if saturated).
    assign w_burst_hit = w_acc & (r_cnt >= C_LAST);

    // ------------------------------------------------------------------------
    // Grant FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (I0_valid && I1_valid) begin
                    // Tie goes to the side that did not hold the last grant.
                    w_next_state = r_last ? GNT0 : GNT1;
                end else if (I0_valid) begin
                    w_next_state = GNT0;
                end else if (I1_valid) begin
                    w_next_state = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (w_oth_valid && (w_burst_hit || !w_cur_valid)) begin
                    w_next_state = (r_state == GNT0) ? GNT1 : GNT0;
                end else if (!w_cur_valid && !w_oth_valid) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Beat counter, round-robin history and mux select
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
            r_cnt  <= '0;
            r_s    <= 1'b0;
        end else begin
            if (w_next_state != r_state) begin
                r_cnt <= '0;
            end else if (w_acc && (r_cnt != C_BURST)) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if ((r_state != IDLE) && (w_next_state != r_state)) begin
                r_last <= (r_state == GNT1);
            end
            // Select tracks the grant and keeps its value through IDLE.
            if (w_next_state != IDLE) begin
                r_s <= (w_next_state == GNT1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output register: loads only on accept, so unaccepted data is never seen
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_acc) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_acc1 ? I1_data : I0_data;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign S         = r_s;
    assign busy      = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
// ============================================================================
//  Module      : tb_mux_rr_arbiter
//  Description : Self-checking bench for mux_rr_arbiter. Two instances
//                (BURST=4 and BURST=1) share one stimulus stream; each is
//                compared every cycle against a behavioural model of the
//                arbitration rules.
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_rr_arbiter;

    localparam int WIDTH = 8;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             I0_valid  = 1'b0;
    logic             I1_valid  = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] I0_data   = '0;
    logic [WIDTH-1:0] I1_data   = '0;

    logic [1:0]       d_i0r;
    logic [1:0]       d_i1r;
    logic [1:0]       d_ov;
    logic [1:0]       d_s;
    logic [1:0]       d_busy;
    logic [WIDTH-1:0] d_od4;
    logic [WIDTH-1:0] d_od1;

    int n_total = 0;
    int n_fail  = 0;

    // Model state, index 0 = BURST 4 instance, index 1 = BURST 1 instance.
    int               burst [2] = '{4, 1};
    int               m_g   [2];   // -1 idle, 0 / 1 = granted requester
    int               m_last[2];
    int               m_cnt [2];
    int               m_ov  [2];
    int               m_s   [2];
    logic [WIDTH-1:0] m_od  [2];

    always #5 clk = ~clk;

    mux_rr_arbiter #(.WIDTH(WIDTH), .BURST(4)) u_b4 (
        .clk(clk), .rst_n(rst_n),
        .I0_valid(I0_valid), .I0_data(I0_data), .I0_ready(d_i0r[0]),
        .I1_valid(I1_valid), .I1_data(I1_data), .I1_ready(d_i1r[0]),
        .out_valid(d_ov[0]), .out_data(d_od4), .out_ready(out_ready),
        .S(d_s[0]), .busy(d_busy[0])
    );

    mux_rr_arbiter #(.WIDTH(WIDTH), .BURST(1)) u_b1 (
        .clk(clk), .rst_n(rst_n),
        .I0_valid(I0_valid), .I0_data(I0_data), .I0_ready(d_i0r[1]),
        .I1_valid(I1_valid), .I1_data(I1_data), .I1_ready(d_i1r[1]),
        .out_valid(d_ov[1]), .out_data(d_od1), .out_ready(out_ready),
        .S(d_s[1]), .busy(d_busy[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_g[k]    = -1;
            m_last[k] = 1;
            m_cnt[k]  = 0;
            m_ov[k]   = 0;
            m_s[k]    = 0;
            m_od[k]   = '0;
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 2; k++) begin
            logic space;
            logic [WIDTH-1:0] od;
            space = (m_ov[k] == 0) || out_ready;
            od    = (k == 0) ? d_od4 : d_od1;
            chk($sformatf("B%0d_I0_ready", burst[k]), 32'(d_i0r[k]), 32'((m_g[k] == 0) && space));
            chk($sformatf("B%0d_I1_ready", burst[k]), 32'(d_i1r[k]), 32'((m_g[k] == 1) && space));
            chk($sformatf("B%0d_out_valid", burst[k]), 32'(d_ov[k]), 32'(m_ov[k]));
            chk($sformatf("B%0d_out_data", burst[k]), 32'(od), 32'(m_od[k]));
            chk($sformatf("B%0d_S", burst[k]), 32'(d_s[k]), 32'(m_s[k]));
            chk($sformatf("B%0d_busy", burst[k]), 32'(d_busy[k]), 32'(m_g[k] >= 0));
        end
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit               v[2];
            logic [WIDTH-1:0] d[2];
            bit               acc;
            bit               hit;
            int               x;
            int               o;
            v[0] = I0_valid;
            v[1] = I1_valid;
            d[0] = I0_data;
            d[1] = I1_data;
            acc  = 1'b0;
            if (m_g[k] >= 0) acc = v[m_g[k]] && ((m_ov[k] == 0) || out_ready);
            if (acc) begin
                m_ov[k] = 1;
                m_od[k] = d[m_g[k]];
            end else if (out_ready) begin
                m_ov[k] = 0;
            end
            if (m_g[k] < 0) begin
                if (v[0] && v[1])  m_g[k] = 1 - m_last[k];
                else if (v[0])     m_g[k] = 0;
                else if (v[1])     m_g[k] = 1;
                m_cnt[k] = 0;
            end else begin
                x   = m_g[k];
                o   = 1 - x;
                hit = acc && (m_cnt[k] + 1 >= burst[k]);
                if (acc && m_cnt[k] < burst[k]) m_cnt[k]++;
                if (v[o] && (hit || !v[x])) begin
                    m_last[k] = x;
                    m_g[k]    = o;
                    m_cnt[k]  = 0;
                end else if (!v[x] && !v[o]) begin
                    m_last[k] = x;
                    m_g[k]    = -1;
                    m_cnt[k]  = 0;
                end
            end
            if (m_g[k] >= 0) m_s[k] = m_g[k];
        end
    endtask

    task automatic cycle(input logic v0, input logic v1, input logic rdy,
                         input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1);
        @(negedge clk);
        I0_valid  = v0;
        I1_valid  = v1;
        out_ready = rdy;
        I0_data   = d0;
        I1_data   = d1;
        #1;
        check_outputs();
        @(posedge clk);
        model_step();
    endtask

    task automatic rand_cycle(input int pv, input int pr);
        cycle(($urandom_range(0, 99) < pv), ($urandom_range(0, 99) < pv),
              ($urandom_range(0, 99) < pr), 8'($urandom), 8'($urandom));
    endtask

    // Reset asserted between edges: outputs must clear without a clock.
    task automatic async_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Reset state, then a single requester streaming three beats.
        cycle(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        cycle(1'b1, 1'b0, 1'b1, 8'h11, 8'h00);
        cycle(1'b1, 1'b0, 1'b1, 8'h11, 8'h00);
        cycle(1'b1, 1'b0, 1'b1, 8'h22, 8'h00);
        cycle(1'b1, 1'b0, 1'b1, 8'h33, 8'h00);
        cycle(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        cycle(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);

        // Both requesters valid continuously: burst alternation.
        for (int i = 0; i < 24; i++) begin
            cycle(1'b1, 1'b1, 1'b1, 8'(8'h40 + i), 8'(8'h80 + i));
        end

        // Backpressure with a full output register, then release.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 8'(8'hA0 + i), 8'(8'hC0 + i));
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b1, 1'b1, 8'(8'hA4 + i), 8'(8'hC4 + i));
        end

        // Early release: I0 drops after two beats while I1 waits, then a tie from IDLE.
        cycle(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        cycle(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        cycle(1'b1, 1'b0, 1'b1, 8'h51, 8'h00);
        cycle(1'b1, 1'b1, 1'b1, 8'h52, 8'h61);
        cycle(1'b1, 1'b1, 1'b1, 8'h53, 8'h62);
        cycle(1'b0, 1'b1, 1'b1, 8'h00, 8'h63);
        cycle(1'b0, 1'b1, 1'b1, 8'h00, 8'h64);
        cycle(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        cycle(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        cycle(1'b1, 1'b1, 1'b1, 8'h71, 8'h91);
        cycle(1'b1, 1'b1, 1'b1, 8'h72, 8'h92);
        cycle(1'b1, 1'b1, 1'b1, 8'h73, 8'h93);

        // Randomised traffic with mixed backpressure.
        for (int i = 0; i < 300; i++) rand_cycle(70, 65);

        // Async reset in the middle of a burst with the output register full.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1, 8'(8'hE0 + i), 8'(8'hF0 + i));
        cycle(1'b1, 1'b1, 1'b0, 8'hE3, 8'hF3);
        async_reset();
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b1, 8'(8'h20 + i), 8'(8'h30 + i));

        // More randomised traffic, heavier load and lighter load.
        for (int i = 0; i < 300; i++) rand_cycle(90, 80);
        for (int i = 0; i < 200; i++) rand_cycle(35, 50);

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

endmodule

`default_nettype wire
